// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// ---------------------------------------------------------------------------
// This block controls the modes of the min:sec clock datapath.
// It sits between the button conditioner / 1 Hz tick source and the two
// chained mod-60 counters. The block has three modes:
//   - RUN     : time counts on en1hz; edit buttons are ignored.
//   - SET_MIN : btn_inc bumps the minutes, and the minutes field is shown
//               and blinks.
//   - SET_SEC : btn_inc bumps the seconds, and the seconds field is shown
//               and blinks.
// btn_mode cycles RUN -> SET_MIN -> SET_SEC -> RUN.
// A set mode falls back to RUN after TIMEOUT_SEC seconds without any button
// press.
//
// Parameters
//   BLINK_CYCLES : clk cycles per blink half-period (>= 2)
//   TIMEOUT_SEC  : idle seconds before a set mode returns to RUN (1..255)
//
// Ports
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   en1hz      : one-cycle tick, once per second
//   btn_mode   : single-cycle pulse, advances the mode
//   btn_inc    : single-cycle pulse, increments the selected field
//   btn_clr    : single-cycle pulse, clears the time
//   sw_min     : display select in RUN (0 = seconds, 1 = minutes)
//   sec_cen    : seconds counter count enable (combinational)
//   sec_inc    : registered one-cycle seconds increment pulse
//   min_inc    : registered one-cycle minutes increment pulse
//   clr        : registered one-cycle clear pulse to both counters
//   disp_sel   : displayed field (0 = seconds, 1 = minutes)
//   blank      : 1 = display digits off (blink phase in set modes)
//   mode       : FSM state, 00 RUN / 01 SET_MIN / 10 SET_SEC
//                This output also serves as the state debug port.
//
// There are no valid/ready handshakes in this block. Every input is a
// qualified single-cycle pulse or a level. Every pulse output is high for
// exactly one cycle, and there is no back-pressure.
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int TIMEOUT_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       sw_min,
  output logic       sec_cen,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       clr,
  output logic       disp_sel,
  output logic       blank,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_SEC = 2'b10
  } state_e;

  localparam int              BW           = $clog2(BLINK_CYCLES);
  localparam logic [BW-1:0]   BLINK_LAST   = BW'(BLINK_CYCLES - 1);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT_SEC);

  state_e        state_q, state_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          clr_q, clr_d;

  logic          in_set;
  logic          any_btn;
  logic          timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      to_cnt_q    <= 8'd0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      clr_q       <= clr_d;
    end
  end

  always_comb begin
    in_set    = (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
    any_btn   = btn_mode | btn_clr | btn_inc;
    // The idle counter is compared as registered. A button pulse in the
    // same cycle as the final en1hz clears the counter, so the compare
    // never becomes true for that tick.
    timed_out = in_set && (to_cnt_q == TIMEOUT_LAST);

    // Next state
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (btn_mode) state_d = ST_SET_MIN;
      ST_SET_MIN: begin
        if (timed_out)     state_d = ST_RUN;
        else if (btn_mode) state_d = ST_SET_SEC;
      end
      ST_SET_SEC: if (timed_out || btn_mode) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    // Edit pulses are decoded with the priority mode > clr > inc.
    // A pulse that loses is dropped, not queued.
    clr_d     = in_set && !btn_mode && btn_clr;
    min_inc_d = (state_q == ST_SET_MIN) && !btn_mode && !btn_clr && btn_inc;
    sec_inc_d = (state_q == ST_SET_SEC) && !btn_mode && !btn_clr && btn_inc;

    // Idle timeout counter
    to_cnt_d = to_cnt_q;
    if (!in_set || any_btn) to_cnt_d = 8'd0;
    else if (en1hz)         to_cnt_d = to_cnt_q + 8'd1;

    // The blink counter restarts on any edit, so the field stays visible
    // for a full half-period after each press.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!in_set || any_btn) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  // Outputs
  always_comb begin
    sec_cen  = en1hz && (state_q == ST_RUN);
    sec_inc  = sec_inc_q;
    min_inc  = min_inc_q;
    clr      = clr_q;
    blank    = in_set && phase_q;
    mode     = in_set ? state_q : ST_RUN;
    disp_sel = sw_min;
    case (state_q)
      ST_SET_MIN: disp_sel = 1'b1;
      ST_SET_SEC: disp_sel = 1'b0;
      default:    disp_sel = sw_min;
    endcase
  end

endmodule
